// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer: drives the program counter's PS select and
// the instruction register, and stops on HALT or an instruction-memory timeout.
module pc_sequencer #(
  parameter int IW         = 16,
  parameter int WAIT_LIMIT = 15,
  parameter int WCW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          imem_req,
  input  logic          imem_rdy,
  input  logic [IW-1:0] imem_data,
  input  logic          exec_done,
  input  logic          z_flag,
  input  logic          n_flag,
  output logic [1:0]    ps,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  output logic          halted,
  output logic          fault,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PS_HOLD   = 2'b00,
    PS_INC    = 2'b01,
    PS_BRANCH = 2'b10,
    PS_LOAD   = 2'b11
  } ps_e;

  localparam logic [3:0]     OP_HALT   = 4'hF;
  localparam logic [3:0]     OP_JMP    = 4'hE;
  localparam logic [3:0]     OP_BRZ    = 4'hD;
  localparam logic [3:0]     OP_BRN    = 4'hC;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = '1;

  state_e         state_q, state_d;
  ps_e            ps_q, ps_d;
  ps_e            ps_next_q, ps_next_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic           ir_valid_q, ir_valid_d;
  logic           halted_q, halted_d;
  logic           fault_q, fault_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]     opcode;

  assign opcode = ir_q[IW-1 -: 4];

  // NOTE: every signal gets its default before the case so no path leaves a
  // variable unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d    = state_q;
    ps_d       = PS_HOLD;
    ps_next_d  = ps_next_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        // A ready on the last allowed cycle still wins over the timeout.
        if (imem_rdy) begin
          ir_d       = imem_data;
          ir_valid_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fault_d    = 1'b1;
          halted_d   = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_HALT;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        unique case (opcode)
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          OP_JMP: begin
            ps_next_d = PS_LOAD;
            state_d   = S_UPDATE;
          end
          OP_BRZ: begin
            ps_next_d = z_flag ? PS_BRANCH : PS_INC;
            state_d   = S_UPDATE;
          end
          OP_BRN: begin
            ps_next_d = n_flag ? PS_BRANCH : PS_INC;
            state_d   = S_UPDATE;
          end
          default: begin
            ps_next_d = PS_INC;
            state_d   = S_EXEC;
          end
        endcase
        if (state_d == S_UPDATE) ps_d = ps_next_d;
      end

      S_EXEC: begin
        if (exec_done) begin
          ps_d    = ps_next_q;
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        ir_valid_d = 1'b0;
        state_d    = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ps_q       <= PS_HOLD;
      ps_next_q  <= PS_HOLD;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      ps_next_q  <= ps_next_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign imem_req = (state_q == S_FETCH);
  assign ps       = ps_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;
  assign fault    = fault_q;
  assign state    = state_q;

endmodule
